// File: rtl/div_4b.sv
// div_4b: sequential unsigned restoring divider.
// One trial subtraction per clock. Quotient and remainder appear after WIDTH
// iterations and are announced by a one-cycle done pulse. A zero divisor
// completes immediately with an all-ones quotient and the dividend as remainder.
module div_4b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] r;          // partial remainder
    logic [WIDTH-1:0] q;          // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvsr;       // divisor captured at start
    logic [CW-1:0]    count;      // completed iterations
    logic [WIDTH:0]   trial;      // shifted remainder minus divisor, MSB is the borrow
    logic [WIDTH-1:0] r_new;
    logic [WIDTH-1:0] q_new;
    logic             last_iter;

    // One restoring step: shift {r,q} left, try the subtraction, keep it if no borrow.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        r_new = {r[WIDTH-2:0], q[WIDTH-1]};
        q_new = {q[WIDTH-2:0], 1'b0};
        // r < 2^i after i iterations, so its MSB is 0 here and {r, q[MSB]} is the
        // zero-extended shifted remainder without any truncation.
        trial = {r, q[WIDTH-1]} - {1'b0, dvsr};
        if (!trial[WIDTH]) begin
            r_new = trial[WIDTH-1:0];
            q_new = {q[WIDTH-2:0], 1'b1};
        end
        last_iter = (count == CW'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (divisor == '0) ? DONE : RUN;
            RUN:  if (last_iter) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Datapath: capture operands, iterate, publish results on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r           <= '0;
            q           <= '0;
            dvsr        <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvsr        <= divisor;
                        r           <= '0;
                        q           <= dividend;
                        count       <= '0;
                        div_by_zero <= (divisor == '0);
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end
                    end
                end
                RUN: begin
                    r     <= r_new;
                    q     <= q_new;
                    count <= count + 1'b1;
                    if (last_iter) begin
                        quotient  <= q_new;
                        remainder <= r_new;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_4b.sv
// tb_div_4b: directed self-checking bench for div_4b.
module tb_div_4b;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks   = 0;
    int failures = 0;

    div_4b #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one request, wait (bounded) for done, check latency, busy length and results.
    task automatic run_div(input logic [3:0] a, input logic [3:0] b, input string tag);
        logic [3:0] eq, er;
        int n, busy_cnt, lat;
        eq  = (b == 4'd0) ? 4'hF : a / b;
        er  = (b == 4'd0) ? a : a % b;
        lat = (b == 4'd0) ? 0 : 4;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = 4'($urandom); divisor = 4'($urandom);
        n = 0; busy_cnt = 0;
        while (done !== 1'b1 && n < 20) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(lat));
        check({tag, " quotient"}, 32'(quotient), 32'(eq));
        check({tag, " remainder"}, 32'(remainder), 32'(er));
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(b == 4'd0));
        check({tag, " busy_in_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n, pulses;
        start = 1'b0; dividend = '0; divisor = '0;
        rst_n = 1'b0;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset remainder", 32'(remainder), 32'd0);
        check("reset dbz", 32'(div_by_zero), 32'd0);
        #22 rst_n = 1'b1;

        // Main case and boundaries.
        run_div(4'd13, 4'd3, "13/3");
        run_div(4'd15, 4'd1, "15/1");
        run_div(4'd7,  4'd9, "7/9");
        run_div(4'd0,  4'd5, "0/5");
        run_div(4'd9,  4'd0, "9/0");
        run_div(4'd15, 4'd9, "15/9");

        // Start pulsed during RUN must be ignored.
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(posedge clk); #1;               // E0
        start = 1'b0;
        @(posedge clk);                   // E1, RUN cycle 2 follows
        @(negedge clk);
        start = 1'b1; dividend = 4'd8; divisor = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ignored_start latency", 32'(n), 32'd2);
        check("ignored_start quotient", 32'(quotient), 32'd4);
        check("ignored_start remainder", 32'(remainder), 32'd1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        check("ignored_start extra_done", 32'(pulses), 32'd0);
        check("hold quotient", 32'(quotient), 32'd4);
        check("hold remainder", 32'(remainder), 32'd1);

        // Asynchronous reset mid-run discards the operation.
        @(negedge clk);
        start = 1'b1; dividend = 4'd14; divisor = 4'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset quotient", 32'(quotient), 32'd0);
        check("midreset remainder", 32'(remainder), 32'd0);
        check("midreset dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        check("midreset no_done", 32'(pulses), 32'd0);
        run_div(4'd14, 4'd4, "14/4 after reset");

        // Exhaustive sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_div(4'(a), 4'(b), $sformatf("sweep %0d/%0d", a, b));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
